// File: rtl/audio_track_scheduler.sv
`default_nettype none
// =============================================================================
// audio_track_scheduler - frame-aligned timed command queues for both Audio
// track control words. Option: TRACK_SCHED_UNDERRUN_EN adds underrun_cnt.
// Revision: 1.0
// =============================================================================
module audio_track_scheduler #(
  parameter int DEPTH = 4,
  parameter int DUR_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             DAC_I2S_WS,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_track,
  input  logic [4:0]       cmd_word,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic [1:0]       flush,
  output logic [4:0]       Track1ControlRegister,
  output logic [4:0]       Track2ControlRegister,
  output logic [1:0]       track_busy,
  output logic [1:0]       fifo_full
`ifdef TRACK_SCHED_UNDERRUN_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 5 + DUR_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  logic       ws_q;
  logic       ws_d;
  logic       tick;
  logic [4:0] word_out [2];

  assign ws_d = DAC_I2S_WS;
  assign tick = ws_q & ~DAC_I2S_WS;

  always_ff @(posedge CLK) begin
    if (Reset) ws_q <= 1'b0;
    else       ws_q <= ws_d;
  end

  assign cmd_ready             = ~fifo_full[cmd_track];
  assign Track1ControlRegister = word_out[0];
  assign Track2ControlRegister = word_out[1];

  for (genvar t = 0; t < 2; t++) begin : g_track
    localparam logic TRK = (t == 1);

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [0:0]       state_q, state_d;
    logic [4:0]       word_q, word_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             flush_act;
    logic             push, pop, empty, full;
    logic [EW-1:0]    head;
    logic             busy;
    logic [4:0]       word_o;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push      = cmd_valid & cmd_ready & (cmd_track == TRK) & ~flush[t];
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    // A flush is remembered until the next frame boundary, where it silences the track.
    assign flush_act = flush[t] | flush_pend_q;

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush[t]) begin
        rd_ptr_d = wr_ptr_q;
      end else begin
        if (push) begin
          mem_d[wr_ptr_q[AW-1:0]] = {cmd_word, cmd_dur};
          wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end

    always_ff @(posedge CLK) begin
      mem_q <= mem_d;
    end

    always_ff @(posedge CLK) begin
      if (Reset) begin
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        state_q      <= ST_IDLE;
        word_q       <= '0;
        cnt_q        <= '0;
        flush_pend_q <= 1'b0;
      end else begin
        wr_ptr_q     <= wr_ptr_d;
        rd_ptr_q     <= rd_ptr_d;
        state_q      <= state_d;
        word_q       <= word_d;
        cnt_q        <= cnt_d;
        flush_pend_q <= flush_pend_d;
      end
    end

    // A zero count in PLAY means sticky: hold until another entry is queued.
    always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      cnt_d        = cnt_q;
      pop          = 1'b0;
      flush_pend_d = flush_act;
      if (tick) begin
        if (flush_act) begin
          state_d      = ST_IDLE;
          word_d       = '0;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end else if (state_q == ST_IDLE || cnt_q == '0 || cnt_q == DUR_W'(1)) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_PLAY;
            word_d  = head[EW-1:DUR_W];
            cnt_d   = head[DUR_W-1:0];
          end else if (state_q == ST_PLAY && cnt_q == DUR_W'(1)) begin
            state_d = ST_IDLE;
            word_d  = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
    end

    always_comb begin
      busy   = (state_q == ST_PLAY);
      word_o = word_q;
    end

    assign word_out[t]   = word_o;
    assign track_busy[t] = busy;
    assign fifo_full[t]  = full;

`ifdef TRACK_SCHED_UNDERRUN_EN
    logic       underrun;
    logic [7:0] urun_q, urun_d;

    assign underrun = tick & ~flush_act & (state_q == ST_PLAY) &
                      (cnt_q == DUR_W'(1)) & empty;

    always_comb begin
      urun_d = urun_q;
      if (flush[t])                           urun_d = '0;
      else if (underrun && urun_q != 8'hFF)   urun_d = urun_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
      if (Reset) urun_q <= '0;
      else       urun_q <= urun_d;
    end

    assign underrun_cnt[8*t +: 8] = urun_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_track_scheduler.sv
`default_nettype none
// tb_audio_track_scheduler - scoreboard bench: expected per-frame outputs are
// queued with the stimulus and compared one cycle after each WS falling edge.
module tb_audio_track_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ws;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_track;
  logic [4:0]  cmd_word;
  logic [15:0] cmd_dur;
  logic [1:0]  flush;
  logic [4:0]  t1, t2;
  logic [1:0]  busy, full;
`ifdef TRACK_SCHED_UNDERRUN_EN
  logic [15:0] underrun_cnt;
`endif

  typedef struct packed {
    logic [4:0] t1;
    logic [4:0] t2;
    logic [1:0] busy;
    logic [1:0] full;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  audio_track_scheduler #(.DEPTH(4), .DUR_W(16)) dut (
    .CLK                   (clk),
    .Reset                 (rst),
    .DAC_I2S_WS            (ws),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_track             (cmd_track),
    .cmd_word              (cmd_word),
    .cmd_dur               (cmd_dur),
    .flush                 (flush),
    .Track1ControlRegister (t1),
    .Track2ControlRegister (t2),
    .track_busy            (busy),
    .fifo_full             (full)
`ifdef TRACK_SCHED_UNDERRUN_EN
    ,
    .underrun_cnt          (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t obs();
    return {t1, t2, busy, full};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    ws = 1'b1;
    step();
    ws = 1'b0;
    step();
  endtask

  task automatic cmd(input logic trk, input logic [4:0] w, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_track = trk;
    cmd_word  = w;
    cmd_dur   = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++; if (t1 !== 5'd0) begin bad++; $display("FAIL reset_t1: got %h want 00", t1); end
    total++; if (t2 !== 5'd0) begin bad++; $display("FAIL reset_t2: got %h want 00", t2); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    total++; if (busy !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b want 00", busy); end
    total++; if (full !== 2'b00) begin bad++; $display("FAIL reset_full: got %b want 00", full); end
  endtask

  task automatic test_single();
    exp_t e;
    cmd(1'b0, 5'h13, 16'd2);
    total++; if (t1 !== 5'd0 || busy !== 2'b00) begin
      bad++; $display("FAIL single_pre_tick: got t1=%h busy=%b want 00/00", t1, busy);
    end
    sb.push_back('{5'h13, 5'h00, 2'b01, 2'b00});
    sb.push_back('{5'h13, 5'h00, 2'b01, 2'b00});
    sb.push_back('{5'h00, 5'h00, 2'b00, 2'b00});
    while (sb.size() > 0) begin
      frame();
      e = sb.pop_front();
      total++; if (obs() !== e) begin bad++; $display("FAIL single_frame: got %h want %h", obs(), e); end
    end
  endtask

  task automatic test_full();
    exp_t e;
    for (int i = 1; i <= 4; i++) begin
      cmd_track = 1'b1;
      #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d: got %b want 1", i, cmd_ready); end
      cmd(1'b1, 5'(i), 16'd1);
    end
    total++; if (full !== 2'b10) begin bad++; $display("FAIL full_flag: got %b want 10", full); end
    cmd_track = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready_trk1: got %b want 0", cmd_ready); end
    cmd_track = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_ready_trk0: got %b want 1", cmd_ready); end
    cmd(1'b1, 5'h1E, 16'd1);
    total++; if (full !== 2'b10) begin bad++; $display("FAIL full_after_5th: got %b want 10", full); end
    sb.push_back('{5'h00, 5'h01, 2'b10, 2'b00});
    sb.push_back('{5'h00, 5'h02, 2'b10, 2'b00});
    sb.push_back('{5'h00, 5'h03, 2'b10, 2'b00});
    sb.push_back('{5'h00, 5'h04, 2'b10, 2'b00});
    sb.push_back('{5'h00, 5'h00, 2'b00, 2'b00});
    while (sb.size() > 0) begin
      frame();
      e = sb.pop_front();
      total++; if (obs() !== e) begin bad++; $display("FAIL full_drain: got %h want %h", obs(), e); end
    end
  endtask

  task automatic test_sticky();
    exp_t e;
    cmd(1'b0, 5'h10, 16'd0);
    repeat (12) sb.push_back('{5'h10, 5'h00, 2'b01, 2'b00});
    while (sb.size() > 0) begin
      frame();
      e = sb.pop_front();
      total++; if (obs() !== e) begin bad++; $display("FAIL sticky_hold: got %h want %h", obs(), e); end
    end
    cmd(1'b0, 5'h05, 16'd1);
    sb.push_back('{5'h05, 5'h00, 2'b01, 2'b00});
    sb.push_back('{5'h00, 5'h00, 2'b00, 2'b00});
    while (sb.size() > 0) begin
      frame();
      e = sb.pop_front();
      total++; if (obs() !== e) begin bad++; $display("FAIL sticky_switch: got %h want %h", obs(), e); end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    cmd(1'b1, 5'h07, 16'd0);
    frame();
    total++; if (t2 !== 5'h07) begin bad++; $display("FAIL flush_start: got %h want 07", t2); end
    for (int i = 0; i < 4; i++) cmd(1'b1, 5'(8 + i), 16'd1);
    total++; if (full !== 2'b10) begin bad++; $display("FAIL flush_prefull: got %b want 10", full); end
    flush = 2'b10;
    step();
    cmd_valid = 1'b1; cmd_track = 1'b1; cmd_word = 5'h0C; cmd_dur = 16'd1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    flush = 2'b00;
    total++; if (full !== 2'b00 || t2 !== 5'h07 || busy !== 2'b10) begin
      bad++; $display("FAIL flush_hold: got full=%b t2=%h busy=%b want 00/07/10", full, t2, busy);
    end
    sb.push_back('{5'h00, 5'h00, 2'b00, 2'b00});
    sb.push_back('{5'h00, 5'h00, 2'b00, 2'b00});
    while (sb.size() > 0) begin
      frame();
      e = sb.pop_front();
      total++; if (obs() !== e) begin bad++; $display("FAIL flush_frame: got %h want %h", obs(), e); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    cmd(1'b0, 5'h11, 16'd1);
    cmd(1'b1, 5'h1F, 16'd2);
    sb.push_back('{5'h11, 5'h1F, 2'b11, 2'b00});
    sb.push_back('{5'h00, 5'h1F, 2'b10, 2'b00});
    sb.push_back('{5'h00, 5'h00, 2'b00, 2'b00});
    while (sb.size() > 0) begin
      frame();
      e = sb.pop_front();
      total++; if (obs() !== e) begin bad++; $display("FAIL both_tracks: got %h want %h", obs(), e); end
    end
    // push lands in the very cycle the tick pops the previous entry
    cmd(1'b0, 5'h14, 16'd1);
    ws = 1'b1;
    step();
    ws = 1'b0;
    cmd_valid = 1'b1; cmd_track = 1'b0; cmd_word = 5'h15; cmd_dur = 16'd1;
    step();
    cmd_valid = 1'b0;
    total++; if (t1 !== 5'h14) begin bad++; $display("FAIL pushpop_first: got %h want 14", t1); end
    sb.push_back('{5'h15, 5'h00, 2'b01, 2'b00});
    sb.push_back('{5'h00, 5'h00, 2'b00, 2'b00});
    while (sb.size() > 0) begin
      frame();
      e = sb.pop_front();
      total++; if (obs() !== e) begin bad++; $display("FAIL pushpop_frame: got %h want %h", obs(), e); end
    end
  endtask

  task automatic test_reset_midplay();
    cmd(1'b0, 5'h12, 16'd0);
    cmd(1'b0, 5'h13, 16'd0);
    frame();
    total++; if (t1 !== 5'h12) begin bad++; $display("FAIL midreset_play: got %h want 12", t1); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (t1 !== 5'd0 || busy !== 2'b00) begin
      bad++; $display("FAIL midreset_abort: got t1=%h busy=%b want 00/00", t1, busy);
    end
    frame();
    total++; if (t1 !== 5'd0) begin bad++; $display("FAIL midreset_fifo: got %h want 00", t1); end
  endtask

`ifdef TRACK_SCHED_UNDERRUN_EN
  task automatic test_underrun();
    for (int i = 0; i < 300; i++) begin
      cmd(1'b0, 5'h01, 16'd1);
      frame();
      frame();
      if (i == 9) begin
        total++; if (underrun_cnt[7:0] !== 8'd10) begin
          bad++; $display("FAIL underrun_10: got %0d want 10", underrun_cnt[7:0]);
        end
      end
    end
    total++; if (underrun_cnt !== 16'h00FF) begin bad++; $display("FAIL underrun_sat: got %h want 00ff", underrun_cnt); end
    flush = 2'b01;
    step();
    flush = 2'b00;
    total++; if (underrun_cnt !== 16'h0000) begin bad++; $display("FAIL underrun_flush: got %h want 0000", underrun_cnt); end
    frame();
  endtask
`endif

  initial begin
    rst = 1'b1; ws = 1'b0; cmd_valid = 1'b0; cmd_track = 1'b0;
    cmd_word = '0; cmd_dur = '0; flush = 2'b00;
    test_reset();
    test_single();
    test_full();
    test_sticky();
    test_flush();
    test_back_to_back();
    test_reset_midplay();
`ifdef TRACK_SCHED_UNDERRUN_EN
    test_underrun();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
